pattern_bist_driver: RTL
========================

// Module: pattern_bist_driver
// PURPOSE
//  Driving/checking end for the merged pattern netlists: generates pseudo-random stimulus
//  on the 11-bit primary-input bus of a pattern block under test and compacts its 8-bit
//  primary-output bus into a signature (MISR). Sits beside each pattern_x_y instance in
//  the regression harness; a single start/done handshake runs one BIST session.
// PARAMETERS
//  IN_W       11       width of stimulus bus (DUT primary inputs, excl. clk/reset)
//  OUT_W      8        width of response bus (DUT primary outputs)
//  CNT_W      16       width of vector counter / num_vec
//  PIPE_LAT   2        DUT input->output latency in cycles (1..7)
//  LFSR_TAPS  11'h500  feedback tap mask (x^11+x^9+1, period 2047)
//  MISR_POLY  8'h1D    MISR feedback polynomial mask
// PORTS
//  blif_clk_net    in   1      single clock, rising edge
//  blif_reset_net  in   1      asynchronous, active-low reset
//  start           in   1      session request, sampled in IDLE/DONE only
//  num_vec         in   CNT_W  vectors to apply, sampled with start
//  seed            in   IN_W   LFSR seed, sampled with start (0 replaced by 1)
//  dut_in          out  IN_W   stimulus to DUT, bit order G1,G2,IN_2..IN_11,IN_1_5,IN_2_5
//  dut_out         in   OUT_W  DUT response
//  busy            out  1      high in RUN and DRAIN
//  done            out  1      high in DONE; signature valid
//  signature       out  OUT_W  MISR contents
//  vec_cnt         out  CNT_W  vectors applied in current/last session
// BEHAVIOUR
//  - Reset (async, low): state=IDLE; dut_in=0, signature=0, vec_cnt=0, busy=0, done=0,
//    valid pipe cleared. Reset mid-session aborts it; no partial signature is kept.
//  - FSM IDLE/RUN/DRAIN/DONE (registered outputs, decoded from state):
//    IDLE|DONE, start=1, num_vec!=0 -> RUN; load lfsr=seed (or 1), signature=0, vec_cnt=0.
//    IDLE|DONE, start=1, num_vec==0 -> DONE next cycle, signature=0, vec_cnt=0.
//    RUN: each cycle dut_in<=lfsr, lfsr<={lfsr[IN_W-2:0],^(lfsr&LFSR_TAPS)}, vec_cnt++,
//         push 1 into valid pipe; after vec_cnt reaches num_vec -> DRAIN.
//    DRAIN: dut_in held at last vector, push 0; when valid pipe empty -> DONE.
//    DONE: outputs frozen; done stays high until next accepted start.
//  - start while busy is ignored; num_vec/seed changes while busy are ignored.
//  - Valid pipe: PIPE_LAT-deep shift of per-vector valid bit; when tail=1 the MISR absorbs
//    dut_out: sig<={sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1]?MISR_POLY:0) ^ dut_out.
//  - Vector k (0-based) on dut_in is the seed advanced k steps; first vector = seed.
//  - Latency: start edge E -> vector 0 on dut_in after E+1; done high at
//    E + num_vec + PIPE_LAT + 1; exactly num_vec responses are compacted.
//  - vec_cnt saturates at num_vec; no wrap. num_vec=2^CNT_W-1 legal; LFSR wraps every 2047.
// STRUCTURE
//  - pattern_bist_pkg: state enum, default LFSR_TAPS/MISR_POLY constants, lfsr_next()
//    and misr_next() functions shared with bench reference model.
//  - One sub-module: pattern_misr (OUT_W, MISR_POLY; clear, enable, data, sig).
//  - LFSR, counter, valid pipe and FSM live in the top; all flops async-cleared by
//    blif_reset_net.
// TESTING
//  - seed=1,num_vec=12,dut_out=0 -> dut_in 001,002,..,100,201,402,005; signature=00.
//  - seed=1,num_vec=3,dut_out=8'h01 -> signature 8'h07, vec_cnt=3, done at E+6.
//  - num_vec=0, start -> done next cycle, signature=00, dut_in unchanged, busy never high.
//  - start pulsed again during RUN -> ignored; same signature as undisturbed run.
//  - reset asserted during DRAIN -> all outputs 0 immediately; new session after release
//    matches golden signature from reference model.
//  - seed=0 -> behaves identically to seed=1; DUT=pattern block, compare 256-vector
//    signature against gate-level golden value.

Source files
------------

// File: rtl/pattern_bist_pkg.sv
// Shared types, default constants and reference step functions
// for the pattern-block BIST driver.
package pattern_bist_pkg;

    localparam int IN_W_DEF     = 11;
    localparam int OUT_W_DEF    = 8;
    localparam int CNT_W_DEF    = 16;
    localparam int PIPE_LAT_DEF = 2;

    localparam logic [IN_W_DEF-1:0]  LFSR_TAPS_DEF = 11'h500;
    localparam logic [OUT_W_DEF-1:0] MISR_POLY_DEF = 8'h1D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    function automatic logic [IN_W_DEF-1:0] lfsr_next(
        input logic [IN_W_DEF-1:0] s
    );
        return {s[IN_W_DEF-2:0], ^(s & LFSR_TAPS_DEF)};
    endfunction

    function automatic logic [OUT_W_DEF-1:0] misr_next(
        input logic [OUT_W_DEF-1:0] sig,
        input logic [OUT_W_DEF-1:0] d
    );
        return {sig[OUT_W_DEF-2:0], 1'b0}
             ^ (sig[OUT_W_DEF-1] ? MISR_POLY_DEF : '0)
             ^ d;
    endfunction

endpackage

// File: rtl/pattern_misr.sv
// Multiple-input signature register compacting the response bus.
// Clear takes priority over enable.
module pattern_misr
    import pattern_bist_pkg::*;
#(
    parameter int               OUT_W     = OUT_W_DEF,
    parameter logic [OUT_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [OUT_W-1:0] data_i,
    output logic [OUT_W-1:0] sig_o
);

    logic [OUT_W-1:0] sig_q;
    logic [OUT_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (enable_i) begin
            sig_d = {sig_q[OUT_W-2:0], 1'b0}
                  ^ (sig_q[OUT_W-1] ? MISR_POLY : '0)
                  ^ data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/pattern_bist_driver.sv
// BIST session driver: LFSR stimulus onto a pattern block, valid pipe
// aligned to its latency, and MISR compaction of its responses.
module pattern_bist_driver
    import pattern_bist_pkg::*;
#(
    parameter int               IN_W      = IN_W_DEF,
    parameter int               OUT_W     = OUT_W_DEF,
    parameter int               CNT_W     = CNT_W_DEF,
    parameter int               PIPE_LAT  = PIPE_LAT_DEF,
    parameter logic [IN_W-1:0]  LFSR_TAPS = LFSR_TAPS_DEF,
    parameter logic [OUT_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [IN_W-1:0]  seed,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] vec_cnt
);

    bist_state_e      state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [IN_W-1:0]  din_q, din_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic             push;
    logic             misr_clr;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        push     = 1'b0;
        misr_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d    = num_vec;
                    cnt_d    = '0;
                    misr_clr = 1'b1;
                    lfsr_d   = (seed == '0) ? IN_W'(1) : seed;
                    state_d  = (num_vec != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                din_d  = lfsr_q;
                lfsr_d = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                push   = 1'b1;
                if (cnt_q != num_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_d == num_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid bits travel alongside the vectors so the MISR only
    // samples responses that belong to this session.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = push;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= ST_IDLE;
            lfsr_q  <= IN_W'(1);
            din_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pipe_q  <= pipe_d;
        end
    end

    pattern_misr #(
        .OUT_W     (OUT_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk_i    (blif_clk_net),
        .rst_ni   (blif_reset_net),
        .clear_i  (misr_clr),
        .enable_i (pipe_q[PIPE_LAT-1]),
        .data_i   (dut_out),
        .sig_o    (signature)
    );

    assign dut_in  = din_q;
    assign vec_cnt = cnt_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);

endmodule
